// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer
//   Feeds the lcd_ctrl image display controller from a host command queue.
//   Host commands land in a small FIFO; each is issued to lcd_ctrl only when
//   the controller is not busy. A LOAD (cmd 0) streams the IMG_N-pixel image
//   out of a sync-read image memory; every command then waits for the
//   OUT_BURST-pulse output burst. Completed commands are counted and short
//   bursts raise a sticky error flag.
//
// Ports
//   clk, reset          clock / async active-low reset
//   host_cmd[2:0]       host command (0 = LOAD, 1..7 = window/zoom)
//   host_cmd_valid/rdy  host push handshake (push on valid && ready)
//   img_addr, img_rd    image memory read port
//   img_data            image memory data, valid the cycle after img_rd
//   lcd_cmd, lcd_cmd_valid  one-cycle command strobe to lcd_ctrl
//   lcd_datain          pixel stream to lcd_ctrl (0 outside LOAD)
//   lcd_busy            lcd_ctrl busy
//   lcd_out_valid       lcd_ctrl output_valid
//   idle                FSM idle and FIFO empty
//   done_cnt            completed commands, wraps
//   burst_err           sticky short-burst flag
module lcd_cmd_sequencer #(
  parameter int DATA_W    = 8,
  parameter int IMG_N     = 108,
  parameter int OUT_BURST = 16,
  parameter int QDEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        host_cmd,
  input  logic              host_cmd_valid,
  output logic              host_cmd_ready,
  output logic [6:0]        img_addr,
  output logic              img_rd,
  input  logic [DATA_W-1:0] img_data,
  output logic [2:0]        lcd_cmd,
  output logic              lcd_cmd_valid,
  output logic [DATA_W-1:0] lcd_datain,
  input  logic              lcd_busy,
  input  logic              lcd_out_valid,
  output logic              idle,
  output logic [7:0]        done_cnt,
  output logic              burst_err
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int AW = 7;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LOAD, S_WAIT_OUT} state_t;

  state_t state, state_n;

  // command FIFO; extra pointer bit distinguishes full from empty
  logic [QDEPTH-1:0][2:0] fifo_mem;
  logic [PW:0]            wptr, rptr;
  logic                   fifo_empty, fifo_full, push, pop;

  logic [2:0]    cmd_q;    // command being executed
  logic [AW-1:0] k_cnt;    // LOAD pixel index, 1..IMG_N
  logic [5:0]    ob_cnt;   // output_valid pulses seen for this command
  logic          fin, err_set;

  assign fifo_empty     = (wptr == rptr);
  assign fifo_full      = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign host_cmd_ready = !fifo_full;
  assign push           = host_cmd_valid && !fifo_full;
  assign idle           = (state == S_IDLE) && fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_mem <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      if (push) begin
        fifo_mem[wptr[PW-1:0]] <= host_cmd;
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n       = state;
    pop           = 1'b0;
    lcd_cmd_valid = 1'b0;
    lcd_cmd       = 3'd0;
    img_rd        = 1'b0;
    img_addr      = '0;
    lcd_datain    = '0;
    fin           = 1'b0;
    err_set       = 1'b0;
    case (state)
      S_IDLE: begin
        // the previous burst has finished by construction, so only the
        // live busy needs checking before popping
        if (!fifo_empty && !lcd_busy) begin
          pop     = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        lcd_cmd_valid = 1'b1;
        lcd_cmd       = cmd_q;
        if (cmd_q == 3'd0) begin
          img_rd  = 1'b1;    // address 0 goes out with the command
          state_n = S_LOAD;
        end else begin
          state_n = S_WAIT_OUT;
        end
      end
      S_LOAD: begin
        // memory is one cycle behind the address, so the data phase runs
        // one cycle past the last read
        lcd_datain = img_data;
        if (k_cnt < AW'(IMG_N)) begin
          img_rd   = 1'b1;
          img_addr = k_cnt;
        end else begin
          state_n = S_WAIT_OUT;
        end
      end
      S_WAIT_OUT: begin
        if (!lcd_busy) begin
          fin     = 1'b1;
          err_set = (ob_cnt < 6'(OUT_BURST));
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q     <= 3'd0;
      k_cnt     <= '0;
      ob_cnt    <= '0;
      done_cnt  <= 8'd0;
      burst_err <= 1'b0;
    end else begin
      if (pop) cmd_q <= fifo_mem[rptr[PW-1:0]];

      if (state == S_ISSUE)     k_cnt <= AW'(1);
      else if (state == S_LOAD) k_cnt <= k_cnt + 1'b1;

      // pulses arriving during ISSUE/LOAD belong to this command too;
      // extras beyond the burst saturate rather than wrap
      if (pop || fin)
        ob_cnt <= '0;
      else if (state != S_IDLE && lcd_out_valid && ob_cnt < 6'(OUT_BURST))
        ob_cnt <= ob_cnt + 1'b1;

      if (fin)     done_cnt  <= done_cnt + 8'd1;
      if (err_set) burst_err <= 1'b1;
    end
  end

endmodule
